// File: rtl/ps2_rx_ctrl_if.sv
// FIFO write-side bundle between the PS/2 frame sequencer and the ps2_buffer FIFO.
// The sequencer is the master: it drives data and strobe and observes the full flag.
interface ps2_rx_ctrl_if;
  logic       fifo_full;
  logic [7:0] fifo_din;
  logic       fifo_wr_en;

  modport master (
    input  fifo_full,
    output fifo_din,
    output fifo_wr_en
  );

  modport slave (
    output fifo_full,
    input  fifo_din,
    input  fifo_wr_en
  );
endinterface

// File: rtl/ps2_rx_ctrl.sv
// PS/2 receive frame sequencer: start/8 data/odd parity/stop, one FIFO write per good byte,
// saturating debug counters. Entirely in the inverted PS/2 clock domain.
module ps2_rx_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic               ps2_clkn,
  input  logic               rst,
  input  logic               ps2_data,
  ps2_rx_ctrl_if.master      fifo,
  output logic               busy,
  output logic [CNT_W-1:0]   parity_err_cnt,
  output logic [CNT_W-1:0]   frame_err_cnt,
  output logic [CNT_W-1:0]   drop_cnt
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shreg;
  logic        parity_ok;

  logic        wr_en;
  logic        par_err_inc;
  logic        frame_err_inc;
  logic        drop_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + CNT_W'(1);
  endfunction

  always_ff @(posedge ps2_clkn) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!ps2_data) state_nxt = DATA;
      DATA:    if (bit_cnt == 3'd7) state_nxt = PARITY;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The write strobe is Mealy so the FIFO captures on the STOP edge itself;
  // a registered strobe would only be seen on the next frame's first clock.
  always_comb begin
    wr_en         = 1'b0;
    par_err_inc   = 1'b0;
    frame_err_inc = 1'b0;
    drop_inc      = 1'b0;
    if (state == STOP && !rst) begin
      if (!ps2_data)       frame_err_inc = 1'b1;
      else if (!parity_ok) par_err_inc   = 1'b1;
      else if (fifo.fifo_full) drop_inc  = 1'b1;
      else                 wr_en         = 1'b1;
    end
  end

  assign fifo.fifo_wr_en = wr_en;
  assign fifo.fifo_din   = shreg;
  assign busy            = (state != IDLE) && !rst;

  always_ff @(posedge ps2_clkn) begin
    if (rst) begin
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      parity_ok <= 1'b0;
    end else begin
      unique case (state)
        IDLE: bit_cnt <= 3'd0;
        DATA: begin
          shreg   <= {ps2_data, shreg[7:1]};
          bit_cnt <= bit_cnt + 3'd1;
        end
        PARITY:  parity_ok <= (^shreg) ^ ps2_data;
        STOP:    bit_cnt   <= 3'd0;
        default: bit_cnt   <= 3'd0;
      endcase
    end
  end

  // At most one counter steps per frame; stop error outranks parity error.
  always_ff @(posedge ps2_clkn) begin
    if (rst) begin
      parity_err_cnt <= '0;
      frame_err_cnt  <= '0;
      drop_cnt       <= '0;
    end else begin
      if (par_err_inc)   parity_err_cnt <= sat_inc(parity_err_cnt);
      if (frame_err_inc) frame_err_cnt  <= sat_inc(frame_err_cnt);
      if (drop_inc)      drop_cnt       <= sat_inc(drop_cnt);
    end
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Bench for ps2_rx_ctrl: vector table of frames, mid-frame reset, random frames
// against a frame-level model, and counter saturation.
module tb_ps2_rx_ctrl;
  logic       ps2_clkn = 1'b0;
  logic       rst      = 1'b1;
  logic       ps2_data = 1'b1;
  logic       busy;
  logic [7:0] parity_err_cnt;
  logic [7:0] frame_err_cnt;
  logic [7:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  // frame-level model state
  int m_par  = 0;
  int m_frm  = 0;
  int m_drop = 0;

  ps2_rx_ctrl_if fif ();

  ps2_rx_ctrl #(.CNT_W(8)) dut (
    .ps2_clkn       (ps2_clkn),
    .rst            (rst),
    .ps2_data       (ps2_data),
    .fifo           (fif.master),
    .busy           (busy),
    .parity_err_cnt (parity_err_cnt),
    .frame_err_cnt  (frame_err_cnt),
    .drop_cnt       (drop_cnt)
  );

  always #10 ps2_clkn = ~ps2_clkn;

  typedef struct {
    logic [7:0] data;
    logic       bad_par;
    logic       stop;
    logic       full;
    int         gap;
    logic       exp_wr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, " parity_err_cnt"}, 32'(parity_err_cnt), 32'(m_par));
    chk({tag, " frame_err_cnt"},  32'(frame_err_cnt),  32'(m_frm));
    chk({tag, " drop_cnt"},       32'(drop_cnt),       32'(m_drop));
  endtask

  function automatic int sat8(input int v);
    return (v < 255) ? v + 1 : 255;
  endfunction

  task automatic do_reset();
    @(negedge ps2_clkn);
    rst = 1'b1; ps2_data = 1'b1; fif.fifo_full = 1'b0;
    #1;
    chk("reset wr_en", 32'(fif.fifo_wr_en), 0);
    chk("reset busy",  32'(busy), 0);
    @(negedge ps2_clkn);
    rst = 1'b0;
    #1;
    m_par = 0; m_frm = 0; m_drop = 0;
    chk("post-reset busy", 32'(busy), 0);
    chk("post-reset din",  32'(fif.fifo_din), 0);
    chk_counters("post-reset");
  endtask

  task automatic idle_bits(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge ps2_clkn);
      ps2_data = 1'b1; fif.fifo_full = 1'b0;
      #1;
      chk("idle wr_en", 32'(fif.fifo_wr_en), 0);
      chk("idle busy",  32'(busy), 0);
    end
  endtask

  // Drive one 11-bit frame; exp_wr is what the caller expects at the stop bit.
  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop,
                            input logic full, input logic exp_wr, input string tag);
    logic [10:0] bits;
    logic        p;
    int          stray;
    int          busy_low;
    p        = (~^b) ^ bad_par;
    bits     = {stop, p, b, 1'b0};
    stray    = 0;
    busy_low = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge ps2_clkn);
      ps2_data = bits[i]; fif.fifo_full = full;
      #1;
      if (i == 0) chk_counters({tag, " start"});
      if (i >= 1 && !busy) busy_low++;
      if (i < 10 && fif.fifo_wr_en) stray++;
      if (i == 9) chk({tag, " din@parity"}, 32'(fif.fifo_din), 32'(b));
      if (i == 10) begin
        chk({tag, " wr_en@stop"}, 32'(fif.fifo_wr_en), 32'(exp_wr));
        chk({tag, " din@stop"},   32'(fif.fifo_din),   32'(b));
      end
    end
    chk({tag, " stray writes"}, 32'(stray), 0);
    chk({tag, " busy gaps"},    32'(busy_low), 0);
    if (!stop)                m_frm  = sat8(m_frm);
    else if (!(^{b, p}))      m_par  = sat8(m_par);
    else if (full)            m_drop = sat8(m_drop);
  endtask

  initial begin
    vec_t vecs [10];
    logic [10:0] abort_bits;
    logic [7:0]  rb;
    logic        rbad, rstop, rfull, rexp;

    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b0, 1, 1'b1};  // first good frame after reset
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1, 1'b1};  // back-to-back pair
    vecs[2] = '{8'h1C, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    vecs[3] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1, 1'b0};  // bad parity
    vecs[4] = '{8'h1C, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    vecs[5] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1, 1'b0};  // stop bit 0
    vecs[6] = '{8'hF0, 1'b0, 1'b1, 1'b1, 1, 1'b0};  // FIFO full -> drop
    vecs[7] = '{8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b1};
    vecs[8] = '{8'hFF, 1'b0, 1'b1, 1'b0, 2, 1'b1};
    vecs[9] = '{8'hA5, 1'b1, 1'b0, 1'b0, 0, 1'b0};  // stop error outranks parity

    fif.fifo_full = 1'b0;
    do_reset();

    for (int v = 0; v < 10; v++) begin
      idle_bits(vecs[v].gap);
      send_frame(vecs[v].data, vecs[v].bad_par, vecs[v].stop, vecs[v].full,
                 vecs[v].exp_wr, $sformatf("vec%0d", v));
    end
    idle_bits(1);
    chk_counters("after table");
    chk("table parity_err", 32'(parity_err_cnt), 1);
    chk("table frame_err",  32'(frame_err_cnt), 2);
    chk("table drop",       32'(drop_cnt), 1);

    // Reset on the 5th edge of a frame, then a clean frame.
    abort_bits = {1'b1, 1'b0, 8'h1C, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge ps2_clkn);
      ps2_data = abort_bits[i];
      #1;
      chk("abort wr_en", 32'(fif.fifo_wr_en), 0);
    end
    @(negedge ps2_clkn);
    rst = 1'b1; ps2_data = abort_bits[4];
    #1;
    chk("abort rst wr_en", 32'(fif.fifo_wr_en), 0);
    @(negedge ps2_clkn);
    rst = 1'b0; ps2_data = 1'b1;
    #1;
    m_par = 0; m_frm = 0; m_drop = 0;
    chk("abort busy after reset", 32'(busy), 0);
    chk_counters("abort");
    send_frame(8'h1C, 1'b0, 1'b1, 1'b0, 1'b1, "post-abort");

    // Random frames against the model.
    for (int n = 0; n < 150; n++) begin
      rb    = 8'($urandom);
      rbad  = ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 7) != 0);
      rfull = ($urandom_range(0, 5) == 0);
      rexp  = rstop && !rbad && !rfull;
      idle_bits($urandom_range(0, 2));
      send_frame(rb, rbad, rstop, rfull, rexp, "rand");
    end
    idle_bits(1);
    chk_counters("after random");

    // Saturation of parity_err_cnt.
    do_reset();
    for (int n = 0; n < 255; n++)
      send_frame(8'($urandom), 1'b1, 1'b1, 1'b0, 1'b0, "sat");
    idle_bits(1);
    chk("parity_err_cnt at 255", 32'(parity_err_cnt), 32'hFF);
    send_frame(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, "sat256");
    idle_bits(1);
    chk("parity_err_cnt held", 32'(parity_err_cnt), 32'hFF);
    chk_counters("after saturation");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
